// File: rtl/cpu_muldiv_ctrl_pkg.sv
// Shared CPU definitions: decoded operation codes and multiply/divide sequencer types.
package cpu_muldiv_ctrl_pkg;

  typedef enum logic [4:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_SLT,
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU,
    OP_MTHI,
    OP_MTLO,
    OP_MFHI,
    OP_MFLO
  } Oper_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } MulDivState_t;

  localparam int unsigned MULDIV_ITERS = 32;

  typedef logic [63:0] DoubleWord_t;

  function automatic logic is_muldiv(input Oper_t op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/cpu_muldiv_step.sv
// One shift-add multiply or restoring divide iteration on a 65-bit accumulator.
module cpu_muldiv_step
  import cpu_muldiv_ctrl_pkg::*;
(
  input  logic        is_div,
  input  logic [64:0] acc,
  input  logic [31:0] operand,
  output logic [64:0] acc_next
);

  logic [32:0] sum;
  logic [64:0] sh;
  logic [32:0] rem_sub;

  always_comb begin
    sum      = '0;
    sh       = '0;
    rem_sub  = '0;
    acc_next = acc;
    if (is_div) begin
      sh      = {acc[63:0], 1'b0};
      // Borrow out of the 33-bit subtract means rem < divisor.
      rem_sub = sh[64:32] - {1'b0, operand};
      if (!rem_sub[32]) begin
        acc_next = {1'b0, rem_sub[31:0], sh[31:1], 1'b1};
      end else begin
        acc_next = sh;
      end
    end else begin
      sum = {1'b0, acc[63:32]} + {1'b0, operand};
      if (acc[0]) begin
        acc_next = {1'b0, sum, acc[31:1]};
      end else begin
        acc_next = acc >> 1;
      end
    end
  end

endmodule

// File: rtl/cpu_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; stalls EX while it runs.
module cpu_muldiv_ctrl
  import cpu_muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  Oper_t       op,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CNT_W = $clog2(MULDIV_ITERS);

  MulDivState_t st;
  logic [CNT_W-1:0] cnt;
  logic [64:0] acc;
  logic [64:0] acc_next;
  logic [31:0] opnd;
  logic        is_div;
  logic        res_neg;
  logic        rem_neg;
  logic        div_zero;

  logic        accept;
  logic        sgn;
  logic        op_is_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag1;
  logic [31:0] mag2;
  DoubleWord_t prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  cpu_muldiv_step u_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (acc_next)
  );

  always_comb begin
    accept    = (st == IDLE) && start && !flush && is_muldiv(op);
    sgn       = op inside {OP_MULT, OP_DIV};
    op_is_div = op inside {OP_DIV, OP_DIVU};
    a_neg     = sgn && reg1[31];
    b_neg     = sgn && reg2[31];
    mag1      = a_neg ? (~reg1 + 32'd1) : reg1;
    mag2      = b_neg ? (~reg2 + 32'd1) : reg2;
    prod_fix  = res_neg ? (~acc[63:0] + 64'd1) : acc[63:0];
    quot_fix  = res_neg ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_fix   = rem_neg ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  assign stall_req = !rst && (accept || (st == BUSY));
  assign done      = (st == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (flush) begin
      st <= IDLE;
    end else begin
      case (st)
        IDLE: begin
          if (accept) begin
            is_div   <= op_is_div;
            res_neg  <= a_neg ^ b_neg;
            rem_neg  <= a_neg && op_is_div;
            cnt      <= '0;
            div_zero <= op_is_div && (reg2 == '0);
            if (op_is_div && (reg2 == '0)) begin
              // Divide by zero keeps the raw dividend so HI reports it unmodified.
              acc <= {33'd0, reg1};
              st  <= DONE;
            end else begin
              acc  <= {33'd0, op_is_div ? mag1 : mag2};
              opnd <= op_is_div ? mag2 : mag1;
              st   <= BUSY;
            end
          end else if (start && op == OP_MTHI) begin
            hi <= reg1;
          end else if (start && op == OP_MTLO) begin
            lo <= reg1;
          end
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(MULDIV_ITERS - 1)) begin
            st <= DONE;
          end
        end
        DONE: begin
          if (div_zero) begin
            hi <= acc[31:0];
            lo <= '1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_muldiv_ctrl.sv
// Directed bench for cpu_muldiv_ctrl: reset, multiply, divide, divide-by-zero, flush, MTHI/MTLO.
module tb_cpu_muldiv_ctrl;
  import cpu_muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        start;
  Oper_t       op;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  cpu_muldiv_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (start),
    .op        (op),
    .reg1      (reg1),
    .reg2      (reg2),
    .stall_req (stall_req),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input Oper_t o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi_e,
                        input logic [31:0] lo_e, input int unsigned stalls_e);
    int unsigned stalls = 0;
    int unsigned cyc = 0;
    logic seen = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; reg1 = a; reg2 = b;
    #1;
    while (cyc < 100) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (stall_req) stalls++;
      @(negedge clk);
      #1;
      cyc++;
    end
    start = 1'b0; op = OP_NOP;
    chk({tag, "_done_seen"}, 64'(seen), 64'(1));
    chk({tag, "_stalls"}, 64'(stalls), 64'(stalls_e));
    @(negedge clk);
    #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'(0));
    chk({tag, "_stall_after"}, 64'(stall_req), 64'(0));
    chk({tag, "_hi"}, 64'(hi), 64'(hi_e));
    chk({tag, "_lo"}, 64'(lo), 64'(lo_e));
  endtask

  initial begin
    int unsigned dones;
    rst = 1'b1; flush = 1'b0; start = 1'b0; op = OP_NOP; reg1 = '0; reg2 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("init_hi", 64'(hi), 64'(0));
    chk("init_stall", 64'(stall_req), 64'(0));
    rst = 1'b0;

    // Load HI so the mid-BUSY reset has something to clear.
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; reg1 = 32'hAAAA_5555;
    #1;
    chk("pre_mthi_stall", 64'(stall_req), 64'(0));
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    #1;
    chk("pre_mthi_hi", 64'(hi), 64'hAAAA_5555);

    @(negedge clk);
    start = 1'b1; op = OP_MULTU; reg1 = 32'd3; reg2 = 32'd4;
    #1;
    repeat (6) @(negedge clk);
    #1;
    chk("busy_stall", 64'(stall_req), 64'(1));
    rst = 1'b1; start = 1'b0; op = OP_NOP;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_stall", 64'(stall_req), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_idle_stall", 64'(stall_req), 64'(0));
    chk("post_rst_idle_done", 64'(done), 64'(0));

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run_op("divu_zero", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1);

    // Flush during BUSY iteration 10 must drop the operation without touching HI/LO.
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; reg1 = 32'd1000; reg2 = 32'd3;
    repeat (11) @(negedge clk);
    flush = 1'b1; start = 1'b0; op = OP_NOP;
    #1;
    chk("flush_cycle_stall", 64'(stall_req), 64'(1));
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_idle_stall", 64'(stall_req), 64'(0));
    chk("flush_done", 64'(done), 64'(0));
    chk("flush_hi", 64'(hi), 64'(7));
    chk("flush_lo", 64'(lo), 64'hFFFF_FFFF);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (done) dones++;
    end
    chk("flush_no_done", 64'(dones), 64'(0));

    // Flush wins over a same-cycle MTHI.
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; reg1 = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; op = OP_NOP; flush = 1'b0;
    #1;
    chk("flush_mthi_hi", 64'(hi), 64'(7));

    @(negedge clk);
    start = 1'b1; op = OP_MTHI; reg1 = 32'h1234;
    #1;
    chk("mthi_stall", 64'(stall_req), 64'(0));
    @(negedge clk);
    op = OP_MTLO; reg1 = 32'h5678;
    #1;
    chk("mtlo_stall", 64'(stall_req), 64'(0));
    chk("mthi_hi", 64'(hi), 64'h1234);
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    #1;
    chk("mtlo_lo", 64'(lo), 64'h5678);
    chk("mtlo_hi_kept", 64'(hi), 64'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
